// File: rtl/ip4_tm_nway.sv
`default_nettype none
// ============================================================================
// Module      : ip4_tm_nway
// Description : N-way, multi-read-port tag/state/count memory for the IP4
//               data cache. Has one-cycle read latency, a registered per-way
//               tag compare and write-first forwarding. After reset, a
//               hardware sweep clears every state and count entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ip4_tm_nway #(
    parameter  int NRP   = 2,
    parameter  int NWAY  = 2,
    parameter  int GRP_W = 2,
    parameter  int IDX_W = 6,
    parameter  int TAG_W = 20,
    parameter  int ST_W  = 2,
    parameter  int CNT_W = 4,
    localparam int WAY_W = (NWAY > 1) ? $clog2(NWAY) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NRP-1:0]                      rd_en,
    input  logic [NRP-1:0][GRP_W-1:0]           rd_grp,
    input  logic [NRP-1:0][IDX_W-1:0]           rd_idx,
    input  logic [NRP-1:0][TAG_W-1:0]           rd_tag,
    input  logic                                wr_tag,
    input  logic                                wr_st,
    input  logic                                wr_cnt,
    input  logic [WAY_W-1:0]                    wr_way,
    input  logic [GRP_W-1:0]                    wr_grp,
    input  logic [IDX_W-1:0]                    wr_idx,
    input  logic [TAG_W-1:0]                    wd_tag,
    input  logic [ST_W-1:0]                     wd_st,
    input  logic [CNT_W-1:0]                    wd_cnt,
    output logic                                busy,
    output logic [NRP-1:0]                      rdo_vld,
    output logic [NRP-1:0][NWAY-1:0][TAG_W-1:0] rdo_tag,
    output logic [NRP-1:0][NWAY-1:0][ST_W-1:0]  rdo_st,
    output logic [NRP-1:0][CNT_W-1:0]           rdo_cnt,
    output logic [NRP-1:0][NWAY-1:0]            rdo_hit,
    output logic [NRP-1:0][WAY_W-1:0]           rdo_hway,
    output logic [NRP-1:0]                      rdo_mhit
);

    localparam int c_set_w = GRP_W + IDX_W;
    localparam int c_sets  = 1 << c_set_w;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_set_w-1:0]   r_sweep;
    logic                 w_run;
    logic [c_set_w-1:0]   w_wset;
    logic                 w_way_ok;

    // Storage: tags are never cleared, state and count are cleared by the sweep
    logic [TAG_W-1:0] r_tag_mem [c_sets][NWAY];
    logic [ST_W-1:0]  r_st_mem  [c_sets][NWAY];
    logic [CNT_W-1:0] r_cnt_mem [c_sets];

    assign w_run    = (r_state == S_RUN);
    assign w_wset   = {wr_grp, wr_idx};
    assign w_way_ok = ({1'b0, wr_way} < (WAY_W + 1)'(NWAY));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave INIT once the last set has been cleared
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            S_INIT: begin
                busy = 1'b1;
                if (&r_sweep) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // Sweep address, advances one set per INIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep <= '0;
        end else if (r_state == S_INIT) begin
            r_sweep <= r_sweep + 1'b1;
        end
    end

    // Memory update: sweep clears in INIT, field writes in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT) begin
                for (int w = 0; w < NWAY; w++) begin
                    r_st_mem[r_sweep][w] <= '0;
                end
                r_cnt_mem[r_sweep] <= '0;
            end else begin
                if (wr_tag && w_way_ok) begin
                    r_tag_mem[w_wset][wr_way] <= wd_tag;
                end
                if (wr_st && w_way_ok) begin
                    r_st_mem[w_wset][wr_way] <= wd_st;
                end
                if (wr_cnt) begin
                    r_cnt_mem[w_wset] <= wd_cnt;
                end
            end
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_port
        logic [c_set_w-1:0]          w_rset;
        logic                        w_fwd;
        logic [NWAY-1:0][TAG_W-1:0]  w_tag;
        logic [NWAY-1:0][ST_W-1:0]   w_st;
        logic [CNT_W-1:0]            w_cnt;
        logic [NWAY-1:0]             w_hit;
        logic [WAY_W-1:0]            w_hway;
        logic                        w_mhit;
        logic                        r_vld;
        logic [NWAY-1:0][TAG_W-1:0]  r_tag;
        logic [NWAY-1:0][ST_W-1:0]   r_st;
        logic [CNT_W-1:0]            r_cnt;
        logic [NWAY-1:0]             r_hit;
        logic [WAY_W-1:0]            r_hway;
        logic                        r_mhit;

        assign w_rset = {rd_grp[p], rd_idx[p]};
        assign w_fwd  = w_run && (w_wset == w_rset);

        // Read with write-first forwarding, then compare every way
        always_comb begin
            w_cnt  = (w_fwd && wr_cnt) ? wd_cnt : r_cnt_mem[w_rset];
            w_hway = '0;
            w_mhit = 1'b0;
            for (int w = 0; w < NWAY; w++) begin
                w_tag[w] = r_tag_mem[w_rset][w];
                w_st[w]  = r_st_mem[w_rset][w];
                if (w_fwd && w_way_ok && (int'(wr_way) == w)) begin
                    if (wr_tag) begin
                        w_tag[w] = wd_tag;
                    end
                    if (wr_st) begin
                        w_st[w] = wd_st;
                    end
                end
                w_hit[w] = (w_tag[w] == rd_tag[p]) && (w_st[w] != '0);
            end
            // Scan downward so the lowest hitting way wins
            for (int w = NWAY - 1; w >= 0; w--) begin
                if (w_hit[w]) begin
                    w_hway = WAY_W'(w);
                end
            end
            w_mhit = ($countones(w_hit) > 1);
        end

        // Result registers: capture on an accepted read, hold otherwise
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld  <= 1'b0;
                r_tag  <= '0;
                r_st   <= '0;
                r_cnt  <= '0;
                r_hit  <= '0;
                r_hway <= '0;
                r_mhit <= 1'b0;
            end else begin
                r_vld <= w_run && rd_en[p];
                if (w_run && rd_en[p]) begin
                    r_tag  <= w_tag;
                    r_st   <= w_st;
                    r_cnt  <= w_cnt;
                    r_hit  <= w_hit;
                    r_hway <= w_hway;
                    r_mhit <= w_mhit;
                end
            end
        end

        assign rdo_vld[p]  = r_vld;
        assign rdo_tag[p]  = r_tag;
        assign rdo_st[p]   = r_st;
        assign rdo_cnt[p]  = r_cnt;
        assign rdo_hit[p]  = r_hit;
        assign rdo_hway[p] = r_hway;
        assign rdo_mhit[p] = r_mhit;
    end

endmodule
`default_nettype wire

// File: tb/tb_ip4_tm_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip4_tm_nway
// Description : Self-checking bench for ip4_tm_nway using a reference model
//               and a per-port expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip4_tm_nway;

    localparam int NRP   = 2;
    localparam int NWAY  = 2;
    localparam int GRP_W = 2;
    localparam int IDX_W = 6;
    localparam int TAG_W = 20;
    localparam int ST_W  = 2;
    localparam int CNT_W = 4;
    localparam int WAY_W = 1;
    localparam int SETS  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                rst;
    logic [NRP-1:0]                      rd_en;
    logic [NRP-1:0][GRP_W-1:0]           rd_grp;
    logic [NRP-1:0][IDX_W-1:0]           rd_idx;
    logic [NRP-1:0][TAG_W-1:0]           rd_tag;
    logic                                wr_tag;
    logic                                wr_st;
    logic                                wr_cnt;
    logic [WAY_W-1:0]                    wr_way;
    logic [GRP_W-1:0]                    wr_grp;
    logic [IDX_W-1:0]                    wr_idx;
    logic [TAG_W-1:0]                    wd_tag;
    logic [ST_W-1:0]                     wd_st;
    logic [CNT_W-1:0]                    wd_cnt;
    logic                                busy;
    logic [NRP-1:0]                      rdo_vld;
    logic [NRP-1:0][NWAY-1:0][TAG_W-1:0] rdo_tag;
    logic [NRP-1:0][NWAY-1:0][ST_W-1:0]  rdo_st;
    logic [NRP-1:0][CNT_W-1:0]           rdo_cnt;
    logic [NRP-1:0][NWAY-1:0]            rdo_hit;
    logic [NRP-1:0][WAY_W-1:0]           rdo_hway;
    logic [NRP-1:0]                      rdo_mhit;

    ip4_tm_nway #(
        .NRP(NRP), .NWAY(NWAY), .GRP_W(GRP_W), .IDX_W(IDX_W),
        .TAG_W(TAG_W), .ST_W(ST_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_grp(rd_grp), .rd_idx(rd_idx), .rd_tag(rd_tag),
        .wr_tag(wr_tag), .wr_st(wr_st), .wr_cnt(wr_cnt), .wr_way(wr_way),
        .wr_grp(wr_grp), .wr_idx(wr_idx),
        .wd_tag(wd_tag), .wd_st(wd_st), .wd_cnt(wd_cnt),
        .busy(busy), .rdo_vld(rdo_vld), .rdo_tag(rdo_tag), .rdo_st(rdo_st),
        .rdo_cnt(rdo_cnt), .rdo_hit(rdo_hit), .rdo_hway(rdo_hway),
        .rdo_mhit(rdo_mhit)
    );

    typedef struct {
        logic [NWAY-1:0][TAG_W-1:0] tag;
        logic [NWAY-1:0]            tagk;
        logic [NWAY-1:0][ST_W-1:0]  st;
        logic [CNT_W-1:0]           cnt;
        logic                       hitk;
        logic [NWAY-1:0]            hit;
        logic [WAY_W-1:0]           hway;
        logic                       mhit;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    // Reference model
    logic [TAG_W-1:0] m_tag  [SETS][NWAY];
    bit               m_tagk [SETS][NWAY];
    logic [ST_W-1:0]  m_st   [SETS][NWAY];
    logic [CNT_W-1:0] m_cnt  [SETS];
    bit               m_busy;
    int               m_sweep;
    bit [NRP-1:0]     exp_vld;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tg, got, exp);
    endtask

    function automatic exp_t mk_exp(input int s, input logic [TAG_W-1:0] t);
        exp_t e;
        int   nh;
        nh     = 0;
        e.hitk = 1'b1;
        e.hit  = '0;
        e.hway = '0;
        for (int w = 0; w < NWAY; w++) begin
            e.tag[w]  = m_tag[s][w];
            e.tagk[w] = m_tagk[s][w];
            e.st[w]   = m_st[s][w];
            if (m_st[s][w] != '0) begin
                if (!m_tagk[s][w]) e.hitk = 1'b0;
                else if (m_tag[s][w] == t) begin
                    e.hit[w] = 1'b1;
                    nh++;
                end
            end
        end
        e.cnt = m_cnt[s];
        for (int w = NWAY - 1; w >= 0; w--) if (e.hit[w]) e.hway = WAY_W'(w);
        e.mhit = (nh > 1);
        return e;
    endfunction

    task automatic cmp(input int p, input exp_t e);
        for (int w = 0; w < NWAY; w++) begin
            if (e.tagk[w]) chk($sformatf("p%0d_tag%0d", p, w), rdo_tag[p][w], e.tag[w]);
            chk($sformatf("p%0d_st%0d", p, w), rdo_st[p][w], e.st[w]);
        end
        chk($sformatf("p%0d_cnt", p), rdo_cnt[p], e.cnt);
        if (e.hitk) begin
            chk($sformatf("p%0d_hit", p), rdo_hit[p], e.hit);
            chk($sformatf("p%0d_hway", p), rdo_hway[p], e.hway);
            chk($sformatf("p%0d_mhit", p), rdo_mhit[p], e.mhit);
        end
    endtask

    // One clock: advance the model for the coming edge, then check the DUT
    task automatic tick();
        int   s;
        exp_t e;
        if (rst) begin
            m_busy  = 1'b1;
            m_sweep = 0;
            exp_vld = '0;
            sb0.delete();
            sb1.delete();
        end else if (m_busy) begin
            for (int w = 0; w < NWAY; w++) m_st[m_sweep][w] = '0;
            m_cnt[m_sweep] = '0;
            if (m_sweep == SETS - 1) m_busy = 1'b0;
            m_sweep++;
            exp_vld = '0;
        end else begin
            s = {wr_grp, wr_idx};
            if (wr_tag) begin
                m_tag[s][wr_way]  = wd_tag;
                m_tagk[s][wr_way] = 1'b1;
            end
            if (wr_st)  m_st[s][wr_way] = wd_st;
            if (wr_cnt) m_cnt[s] = wd_cnt;
            exp_vld = rd_en;
            if (rd_en[0]) sb0.push_back(mk_exp({rd_grp[0], rd_idx[0]}, rd_tag[0]));
            if (rd_en[1]) sb1.push_back(mk_exp({rd_grp[1], rd_idx[1]}, rd_tag[1]));
        end
        @(posedge clk);
        #1;
        chk("busy", busy, m_busy);
        for (int p = 0; p < NRP; p++) begin
            chk($sformatf("p%0d_vld", p), rdo_vld[p], exp_vld[p]);
            if (exp_vld[p]) begin
                e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
                if (rdo_vld[p]) cmp(p, e);
            end
        end
    endtask

    task automatic idle();
        rd_en  = '0;
        wr_tag = 1'b0;
        wr_st  = 1'b0;
        wr_cnt = 1'b0;
    endtask

    task automatic set_rd(input int p, input int s, input logic [TAG_W-1:0] t);
        rd_en[p]  = 1'b1;
        rd_grp[p] = s[IDX_W +: GRP_W];
        rd_idx[p] = s[IDX_W-1:0];
        rd_tag[p] = t;
    endtask

    task automatic set_wr(input int s, input int way,
                          input bit dt, input logic [TAG_W-1:0] t,
                          input bit ds, input logic [ST_W-1:0] st,
                          input bit dc, input logic [CNT_W-1:0] c);
        wr_grp = s[IDX_W +: GRP_W];
        wr_idx = s[IDX_W-1:0];
        wr_way = WAY_W'(way);
        wr_tag = dt;
        wd_tag = t;
        wr_st  = ds;
        wd_st  = st;
        wr_cnt = dc;
        wd_cnt = c;
    endtask

    task automatic rand_reads();
        set_rd(0, $urandom_range(0, SETS - 1), TAG_W'($urandom));
        set_rd(1, $urandom_range(0, SETS - 1), TAG_W'($urandom));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        for (int s = 0; s < SETS; s++) begin
            m_cnt[s] = '0;
            for (int w = 0; w < NWAY; w++) begin
                m_tag[s][w]  = '0;
                m_tagk[s][w] = 1'b0;
                m_st[s][w]   = '0;
            end
        end
        m_busy  = 1'b1;
        m_sweep = 0;
        exp_vld = '0;
        rd_grp  = '0;
        rd_idx  = '0;
        rd_tag  = '0;
        set_wr(0, 0, 0, '0, 0, '0, 0, '0);
        idle();
        rst = 1'b1;
        repeat (3) tick();

        // Reset values
        chk("rst_vld", rdo_vld, 0);
        chk("rst_tag0", rdo_tag[0], 0);
        chk("rst_tag1", rdo_tag[1], 0);
        chk("rst_st", rdo_st, 0);
        chk("rst_cnt", rdo_cnt, 0);
        chk("rst_hit", rdo_hit, 0);
        chk("rst_hway", rdo_hway, 0);
        chk("rst_mhit", rdo_mhit, 0);

        // Init sweep length, reads during busy are ignored
        rst = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            rand_reads();
            tick();
            n++;
        end
        chk("init_len", n, 256);

        // Every set cleared, both ports
        for (int i = 0; i < SETS; i++) begin
            idle();
            set_rd(0, i, TAG_W'($urandom));
            set_rd(1, SETS - 1 - i, TAG_W'($urandom));
            tick();
        end
        idle();
        tick();

        // Single way hit
        set_wr(69, 1, 1, 20'hABCDE, 1, 2'd2, 0, '0);
        tick();
        idle();
        set_rd(0, 69, 20'hABCDE);
        tick();
        chk("abcde_hit", rdo_hit[0], 2'b10);
        chk("abcde_hway", rdo_hway[0], 1);
        chk("abcde_mhit", rdo_mhit[0], 0);
        idle();
        tick();
        chk("hold_hit", rdo_hit[0], 2'b10);

        // Same-cycle write forwarding to both ports
        set_wr(7, 0, 0, '0, 1, 2'd3, 1, 4'd9);
        set_rd(0, 7, '0);
        set_rd(1, 7, '0);
        tick();
        chk("fwd_cnt0", rdo_cnt[0], 9);
        chk("fwd_cnt1", rdo_cnt[1], 9);
        chk("fwd_st0", rdo_st[0][0], 3);
        chk("fwd_st1", rdo_st[1][0], 3);
        idle();

        // Multi-hit, second way written in the same cycle as the lookup
        set_wr(138, 0, 1, 20'h12345, 1, 2'd1, 0, '0);
        tick();
        set_wr(138, 1, 1, 20'h12345, 1, 2'd1, 0, '0);
        set_rd(0, 138, 20'h12345);
        set_rd(1, 138, 20'h12346);
        tick();
        chk("mh_hit", rdo_hit[0], 2'b11);
        chk("mh_hway", rdo_hway[0], 0);
        chk("mh_mhit", rdo_mhit[0], 1);
        chk("miss_hit", rdo_hit[1], 0);
        idle();

        // Random traffic on a small set range with small tag pool
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < NWAY; w++) begin
                set_wr(s, w, 1, 20'h100 + 20'($urandom_range(0, 2)), 1,
                       ST_W'($urandom_range(0, 3)), 1, CNT_W'($urandom));
                tick();
            end
        end
        for (int i = 0; i < 300; i++) begin
            idle();
            set_wr($urandom_range(0, 15), $urandom_range(0, 1),
                   bit'($urandom_range(0, 1)), 20'h100 + 20'($urandom_range(0, 2)),
                   bit'($urandom_range(0, 1)), ST_W'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 1)), CNT_W'($urandom));
            if ($urandom_range(0, 3) != 0) set_rd(0, $urandom_range(0, 15), 20'h100 + 20'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) != 0) set_rd(1, $urandom_range(0, 15), 20'h100 + 20'($urandom_range(0, 2)));
            tick();
        end
        idle();
        tick();

        // Reset with a read in flight
        set_wr(3, 0, 1, 20'h333, 1, 2'd1, 1, 4'd5);
        tick();
        idle();
        set_rd(0, 3, 20'h333);
        set_rd(1, 3, 20'h333);
        rst = 1'b1;
        tick();
        chk("rst_inflight_vld", rdo_vld, 0);
        rst = 1'b0;
        idle();

        // Reset again at sweep count 100
        while (m_sweep < 100) begin
            rand_reads();
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            rand_reads();
            tick();
            n++;
        end
        chk("reinit_len", n, 256);

        // Set 3 state cleared by the sweep
        idle();
        set_rd(0, 3, 20'h333);
        tick();
        chk("s3_st", rdo_st[0][0], 0);
        chk("s3_hit", rdo_hit[0], 0);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
